load_aligner: RTL

//  Read-side counterpart of the DM store path. Captures M-stage load info
//  (funct3, byte offset, rd), then takes the word-addressed DM SRAM read word
//  one cycle later. Extracts, aligns and sign/zero-extends LB/LH/LW/LBU/LHU

---
 rtl/load_aligner.sv | 123 ++++++++++++
 1 files changed

// File: rtl/load_aligner.sv
// Load-side data aligner: captures M-stage load info, takes the DM read word a cycle later,
// and produces the aligned, sign/zero-extended W-stage load result, holding the word across stalls.
module load_aligner #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      M_op,
    input  logic [2:0]      M_funct3,
    input  logic [XLEN-1:0] M_alu_out,
    input  logic [RD_W-1:0] M_rd,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] dm_data_out,
    output logic            W_ld_valid,
    output logic [XLEN-1:0] W_ld_data,
    output logic [RD_W-1:0] W_rd,
    output logic            W_ld_misalign
);

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [2:0] F3_LB   = 3'b000;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_LHU  = 3'b101;

    logic            v_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [RD_W-1:0] rd_q;
    logic [XLEN-1:0] hold_q;
    logic            hold_v_q;

    logic            accept;
    logic [XLEN-1:0] src;
    logic [7:0]      lanes [4];
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] data_ext;
    logic            misalign;

    // Only the byte offset of the effective address matters; the SRAM is word addressed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^M_alu_out[XLEN-1:2];

    always_comb begin
        accept = 1'b0;
        if (M_op == OP_LOAD) begin
            case (M_funct3)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: accept = 1'b1;
                default:                             accept = 1'b0;
            endcase
        end
    end

    // Flush beats stall; while stalled, the first returned word is latched so a
    // changing SRAM output cannot disturb the result waiting in W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q      <= 1'b0;
            f3_q     <= 3'b000;
            off_q    <= 2'b00;
            rd_q     <= '0;
            hold_q   <= '0;
            hold_v_q <= 1'b0;
        end else if (flush) begin
            v_q      <= 1'b0;
            hold_v_q <= 1'b0;
        end else if (stall) begin
            if (v_q && !hold_v_q) begin
                hold_q   <= dm_data_out;
                hold_v_q <= 1'b1;
            end
        end else begin
            v_q      <= accept;
            f3_q     <= M_funct3;
            off_q    <= M_alu_out[1:0];
            rd_q     <= M_rd;
            hold_v_q <= 1'b0;
        end
    end

    assign src = hold_v_q ? hold_q : dm_data_out;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = src[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lanes[off_q];
    assign half_sel = off_q[1] ? src[31:16] : src[15:0];

    always_comb begin
        data_ext = '0;
        case (f3_q)
            F3_LB:   data_ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   data_ext = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LW:   data_ext = src;
            F3_LBU:  data_ext = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  data_ext = {{(XLEN-16){1'b0}}, half_sel};
            default: data_ext = '0;
        endcase
    end

    // Misaligned accesses are flagged but still return data (halves by off[1], words unrotated).
    always_comb begin
        misalign = 1'b0;
        case (f3_q)
            F3_LH, F3_LHU: misalign = off_q[0];
            F3_LW:         misalign = (off_q != 2'b00);
            default:       misalign = 1'b0;
        endcase
    end

    assign W_ld_valid    = v_q;
    assign W_ld_data     = v_q ? data_ext : '0;
    assign W_rd          = v_q ? rd_q : '0;
    assign W_ld_misalign = v_q & misalign;

endmodule
